// File: rtl/uart_host_bridge_pkg.sv
// Shared types and constants for the UART host bridge.
// TX state encoding, handshake timing and default FIFO depths.
package uart_host_pkg;

    typedef enum logic [1:0] {
        T_IDLE = 2'd0,
        T_ACK  = 2'd1,
        T_BUSY = 2'd2
    } tx_state_e;

    localparam int ACK_TIMEOUT    = 4;
    localparam int RX_CAPTURE_LAT = 2;
    localparam int DEF_TX_DEPTH   = 8;
    localparam int DEF_RX_DEPTH   = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/uart_host_bridge_sync_fifo.sv
// Single-clock FIFO with show-ahead head and exact occupancy count.
// A push into a full FIFO is accepted only alongside a pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign count   = cnt_q;
    assign dout    = empty ? '0 : mem_q[rd_q];

    always_comb begin
        wr_d  = push_ok ? wr_q + AW'(1) : wr_q;
        rd_d  = pop_ok ? rd_q + AW'(1) : rd_q;
        cnt_d = cnt_q;
        unique case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: the head is masked while empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_q] <= din;
        end
    end

endmodule

// File: rtl/uart_host_bridge.sv
// Host-side bridge between a valid/ready byte stream and the UART core.
// TX FIFO feeds the core's xmit handshake; RX FIFO captures received bytes.
module uart_host_bridge
    import uart_host_pkg::*;
#(
    parameter int TX_DEPTH = DEF_TX_DEPTH,
    parameter int RX_DEPTH = DEF_RX_DEPTH,
    parameter int CNT_W    = $clog2(max_int(TX_DEPTH, RX_DEPTH)) + 1
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             tx_valid,
    input  logic [7:0]       tx_data,
    output logic             tx_ready,
    output logic             rx_valid,
    output logic [7:0]       rx_data,
    input  logic             rx_ready,
    output logic             rx_overflow,
    input  logic             clr_overflow,
    output logic [CNT_W-1:0] tx_count,
    output logic [CNT_W-1:0] rx_count,
    output logic             xmitH,
    output logic [7:0]       xmit_dataH,
    input  logic             xmit_doneH,
    input  logic [7:0]       rec_dataH,
    input  logic             rec_readyH
);

    localparam int ACK_W = $clog2(ACK_TIMEOUT);
    localparam int LAT   = RX_CAPTURE_LAT;

    logic       tx_full, tx_empty, tx_pop;
    logic [7:0] tx_head;
    logic       rx_full, rx_empty, rx_push, rx_pop, rx_drop;
    logic       rx_event;

    tx_state_e        st_q, st_d;
    logic             xmit_q, xmit_d;
    logic [7:0]       xd_q, xd_d;
    logic [ACK_W-1:0] ack_q, ack_d;

    logic             rdy_prev_q;
    logic             seen_high_q;
    logic [LAT-1:0]   cap_q, cap_d;
    logic             ovf_q, ovf_d;

    assign tx_ready    = ~tx_full;
    assign rx_valid    = ~rx_empty;
    assign rx_overflow = ovf_q;
    assign xmitH       = xmit_q;
    assign xmit_dataH  = xd_q;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (TX_DEPTH),
        .CNT_W (CNT_W)
    ) u_tx_fifo (
        .clk   (sys_clk),
        .rst   (sys_rst),
        .push  (tx_valid & tx_ready),
        .pop   (tx_pop),
        .din   (tx_data),
        .dout  (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    always_comb begin
        st_d   = st_q;
        xmit_d = 1'b0;
        xd_d   = xd_q;
        ack_d  = ack_q;
        tx_pop = 1'b0;
        unique case (st_q)
            T_IDLE: begin
                if (!tx_empty && xmit_doneH) begin
                    xmit_d = 1'b1;
                    xd_d   = tx_head;
                    tx_pop = 1'b1;
                    ack_d  = '0;
                    st_d   = T_ACK;
                end
            end
            // A core that never drops done loses the byte; no retry.
            T_ACK: begin
                if (!xmit_doneH) begin
                    st_d = T_BUSY;
                end else if (ack_q == ACK_W'(ACK_TIMEOUT - 1)) begin
                    st_d = T_IDLE;
                end else begin
                    ack_d = ack_q + ACK_W'(1);
                end
            end
            T_BUSY: begin
                if (xmit_doneH) begin
                    st_d = T_IDLE;
                end
            end
            default: st_d = T_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            st_q   <= T_IDLE;
            xmit_q <= 1'b0;
            xd_q   <= '0;
            ack_q  <= '0;
        end else begin
            st_q   <= st_d;
            xmit_q <= xmit_d;
            xd_q   <= xd_d;
            ack_q  <= ack_d;
        end
    end

    // First 0->1 of rec_readyH after reset is the core waking up, not a byte.
    assign rx_event = rec_readyH & ~rdy_prev_q & seen_high_q;
    assign rx_push  = cap_q[LAT-1];
    assign rx_pop   = rx_ready & rx_valid;
    assign rx_drop  = rx_push & rx_full & ~rx_pop;

    always_comb begin
        cap_d = {cap_q[LAT-2:0], rx_event};
        ovf_d = ovf_q;
        if (rx_drop) begin
            ovf_d = 1'b1;
        end else if (clr_overflow) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rdy_prev_q  <= 1'b0;
            seen_high_q <= 1'b0;
            cap_q       <= '0;
            ovf_q       <= 1'b0;
        end else begin
            rdy_prev_q  <= rec_readyH;
            seen_high_q <= seen_high_q | rec_readyH;
            cap_q       <= cap_d;
            ovf_q       <= ovf_d;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (RX_DEPTH),
        .CNT_W (CNT_W)
    ) u_rx_fifo (
        .clk   (sys_clk),
        .rst   (sys_rst),
        .push  (rx_push),
        .pop   (rx_pop),
        .din   (rec_dataH),
        .dout  (rx_data),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

endmodule
